// File: rtl/lsu_align_if.sv
// lsu_align_if: MEM-stage request/response and data port B bundle.
// master = pipeline + memory side, slave = lsu_align.
interface lsu_align_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [ADDR_W-1:0] req_wdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [ADDR_W-1:0] mem_wdata;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_rdata;
    logic [ADDR_W-1:0] resp_rdata;
    logic              stall;
    logic              misalign;
    logic [ADDR_W-1:0] misalign_addr;

    modport master (
        output req_valid, req_write, req_size,
        output req_unsigned, req_addr, req_wdata,
        output mem_rdata,
        input  mem_addr, mem_wdata, mem_we,
        input  resp_rdata, stall,
        input  misalign, misalign_addr
    );

    modport slave (
        input  req_valid, req_write, req_size,
        input  req_unsigned, req_addr, req_wdata,
        input  mem_rdata,
        output mem_addr, mem_wdata, mem_we,
        output resp_rdata, stall,
        output misalign, misalign_addr
    );
endinterface

// File: rtl/lsu_align.sv
// lsu_align: load extract/extend, sub-word store read-modify-write,
// misalign detection. Optional trap mode: LSU_MISALIGN_TRAP_EN.
// Ports: clk, reset_n (async, active-low), bus (lsu_align_if.slave).
module lsu_align #(
    parameter int ADDR_W = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    lsu_align_if.slave  bus
);
    typedef enum logic {IDLE, MERGE} state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] old_q;
    logic              latch_old;
    logic              mmio;
    logic              is_sub;
    logic              mis;
    logic              sx;
    logic [1:0]        lane;
    logic [7:0]        byte_v;
    logic [15:0]       half_v;
    logic [ADDR_W-1:0] load_v;
    logic [ADDR_W-1:0] merged;
    logic [ADDR_W-1:0] zext_w;
    logic [ADDR_W-1:0] wdata_c;
    logic              we_c;
    logic              stall_c;

    assign mmio   = (bus.req_addr[31:16] == 16'hffff);
    assign is_sub = ~bus.req_size[1];
    assign sx     = ~bus.req_unsigned;

    assign bus.mem_addr = mmio ? bus.req_addr
                               : {bus.req_addr[31:2], 2'b00};

`ifdef LSU_MISALIGN_TRAP_EN
    logic              mis_raw;
    logic              mis_q;
    logic [ADDR_W-1:0] mis_addr_q;

    assign mis_raw = ((bus.req_size == 2'b01) & bus.req_addr[0])
                   | (bus.req_size[1] & (bus.req_addr[1:0] != 2'b00));
    assign mis  = bus.req_valid & mis_raw;
    assign lane = bus.req_addr[1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mis_q      <= 1'b0;
            mis_addr_q <= '0;
        end else begin
            mis_q <= mis;
            if (mis)
                mis_addr_q <= bus.req_addr;
        end
    end

    assign bus.misalign      = mis_q;
    assign bus.misalign_addr = mis_addr_q;
`else
    // Misaligned accesses are silently aligned down.
    assign mis  = 1'b0;
    assign lane = bus.req_size[1] ? 2'b00
                : bus.req_size[0] ? {bus.req_addr[1], 1'b0}
                : bus.req_addr[1:0];

    assign bus.misalign      = 1'b0;
    assign bus.misalign_addr = '0;
`endif

    assign byte_v = bus.mem_rdata[{lane, 3'b000} +: 8];
    assign half_v = bus.mem_rdata[{lane[1], 4'b0000} +: 16];

    always_comb begin
        load_v = bus.mem_rdata;
        unique case (bus.req_size)
            2'b00:   load_v = {{24{sx & byte_v[7]}}, byte_v};
            2'b01:   load_v = {{16{sx & half_v[15]}}, half_v};
            default: load_v = bus.mem_rdata;
        endcase
    end

    assign bus.resp_rdata = mis ? '0 : load_v;

    always_comb begin
        zext_w = bus.req_wdata;
        unique case (bus.req_size)
            2'b00:   zext_w = {24'h0, bus.req_wdata[7:0]};
            2'b01:   zext_w = {16'h0, bus.req_wdata[15:0]};
            default: zext_w = bus.req_wdata;
        endcase
    end

    // Replace the addressed lane of the word read in the IDLE cycle.
    always_comb begin
        merged = old_q;
        if (bus.req_size == 2'b00)
            merged[{lane, 3'b000} +: 8] = bus.req_wdata[7:0];
        else
            merged[{lane[1], 4'b0000} +: 16] = bus.req_wdata[15:0];
    end

    always_comb begin
        state_d   = state_q;
        we_c      = 1'b0;
        stall_c   = 1'b0;
        latch_old = 1'b0;
        wdata_c   = zext_w;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid & bus.req_write & ~mis) begin
                    if (mmio | ~is_sub) begin
                        we_c = 1'b1;
                    end else begin
                        stall_c   = 1'b1;
                        latch_old = 1'b1;
                        state_d   = MERGE;
                    end
                end
            end
            MERGE: begin
                we_c    = 1'b1;
                wdata_c = merged;
                state_d = IDLE;
            end
        endcase
    end

    // Gate with reset_n so a write never leaks during reset.
    assign bus.mem_we    = we_c & reset_n;
    assign bus.stall     = stall_c & reset_n;
    assign bus.mem_wdata = wdata_c;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            old_q   <= '0;
        end else begin
            state_q <= state_d;
            if (latch_old)
                old_q <= bus.mem_rdata;
        end
    end
endmodule
